lsu_req_ctrl: RTL

//   Request/response front end for lsu; sits between the pipeline MEM stage and lsu.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_req_ctrl_if.sv | 39 +++
 rtl/lsu_align_chk.sv | 13 +
 rtl/lsu_req_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU request front end: access-type codes,
// controller state encoding and the alignment rule for sub-word accesses.
package lsu_pkg;

  localparam int DTYPE_WIDTH = 3;

  typedef enum logic [DTYPE_WIDTH-1:0] {
    BYTE               = 3'd0,
    HALF_WORD          = 3'd1,
    FULL_WORD          = 3'd2,
    BYTE_UNSIGNED      = 3'd3,
    HALF_WORD_UNSIGNED = 3'd4
  } dtype_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // Halves need an even address and words a 4-byte aligned one; bytes and
  // unknown codes never count as misaligned here (illegal codes are separate).
  function automatic logic is_misaligned(input logic [DTYPE_WIDTH-1:0] dtype,
                                         input logic [1:0]             addr_lo);
    logic r;
    r = 1'b0;
    case (dtype)
      HALF_WORD, HALF_WORD_UNSIGNED: r = addr_lo[0];
      FULL_WORD:                     r = (addr_lo != 2'b00);
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal_dtype(input logic [DTYPE_WIDTH-1:0] dtype);
    return (dtype > DTYPE_WIDTH'(HALF_WORD_UNSIGNED));
  endfunction

endpackage

// File: rtl/lsu_req_ctrl_if.sv
// Request and response channels between the MEM stage (master) and the
// LSU request controller (slave). Signal suffixes are from the controller's view.
interface lsu_req_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int TAG_WIDTH  = 5
) ();
  import lsu_pkg::*;

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic                   req_we_i;
  logic [ADDR_WIDTH-1:0]  req_addr_i;
  logic [DATA_WIDTH-1:0]  req_wdata_i;
  logic [DTYPE_WIDTH-1:0] req_dtype_i;
  logic [TAG_WIDTH-1:0]   req_tag_i;

  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [DATA_WIDTH-1:0]  rsp_rdata_o;
  logic [TAG_WIDTH-1:0]   rsp_tag_o;
  logic                   rsp_we_o;
  logic                   rsp_fault_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_dtype_i, req_tag_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_tag_o, rsp_we_o, rsp_fault_o,
    output rsp_ready_i
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_dtype_i, req_tag_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_tag_o, rsp_we_o, rsp_fault_o,
    input  rsp_ready_i
  );

endinterface

// File: rtl/lsu_align_chk.sv
// Combinational access check: flags a misaligned half/word or an unknown
// dtype code. Kept separate so an instruction-fetch path can reuse it.
module lsu_align_chk
  import lsu_pkg::*;
(
  input  logic [DTYPE_WIDTH-1:0] i_dtype,
  input  logic [1:0]             i_addr_lo,
  output logic                   o_fault
);

  assign o_fault = is_misaligned(i_dtype, i_addr_lo) | is_illegal_dtype(i_dtype);

endmodule

// File: rtl/lsu_req_ctrl.sv
// One-in-flight request/response front end for the LSU. Accepts a load or
// store, rejects bad accesses without touching memory, drives the LSU for
// the sync-read RAM's latency and returns a held response.
module lsu_req_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int TAG_WIDTH    = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  lsu_req_ctrl_if.slave          bus,
  output logic [ADDR_WIDTH-1:0]  lsu_addr_o,
  output logic [DATA_WIDTH-1:0]  lsu_data_o,
  output logic                   lsu_we_o,
  output logic [DTYPE_WIDTH-1:0] lsu_dtype_o,
  input  logic [DATA_WIDTH-1:0]  lsu_data_i
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_we;
  logic [TAG_WIDTH-1:0]   r_tag;

  logic [ADDR_WIDTH-1:0]  r_lsu_addr;
  logic [DATA_WIDTH-1:0]  r_lsu_data;
  logic                   r_lsu_we;
  logic [DTYPE_WIDTH-1:0] r_lsu_dtype;

  logic                   r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_rdata;
  logic [TAG_WIDTH-1:0]   r_rsp_tag;
  logic                   r_rsp_we;
  logic                   r_rsp_fault;

  logic                   w_fault;

  lsu_align_chk u_align_chk (
    .i_dtype   (bus.req_dtype_i),
    .i_addr_lo (bus.req_addr_i[1:0]),
    .o_fault   (w_fault)
  );

  // NOTE: ready is decoded from state and gated by reset_n so it reads 0 while
  // reset is held yet is already 1 in the first IDLE cycle after release.
  assign bus.req_ready_o = reset_n & (r_state == IDLE);

  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_tag_o   = r_rsp_tag;
  assign bus.rsp_we_o    = r_rsp_we;
  assign bus.rsp_fault_o = r_rsp_fault;

  assign lsu_addr_o  = r_lsu_addr;
  assign lsu_data_o  = r_lsu_data;
  assign lsu_we_o    = r_lsu_we;
  assign lsu_dtype_o = r_lsu_dtype;

  // Request sequencing FSM with all LSU and response outputs registered.
  // NOTE: state is updated with non-blocking assignments so every branch sees
  // the pre-edge values; the async reset clears lsu_we_o without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_tag       <= '0;
      r_lsu_addr  <= '0;
      r_lsu_data  <= '0;
      r_lsu_we    <= 1'b0;
      r_lsu_dtype <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_tag   <= '0;
      r_rsp_we    <= 1'b0;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid_i) begin
            r_we  <= bus.req_we_i;
            r_tag <= bus.req_tag_i;
            if (w_fault) begin
              // Bad access: answer immediately, LSU outputs keep their old values.
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_tag   <= bus.req_tag_i;
              r_rsp_we    <= bus.req_we_i;
              r_rsp_fault <= 1'b1;
            end else begin
              r_state     <= ISSUE;
              r_lsu_addr  <= bus.req_addr_i;
              r_lsu_data  <= bus.req_wdata_i;
              r_lsu_dtype <= bus.req_dtype_i;
              r_lsu_we    <= bus.req_we_i;
            end
          end
        end

        ISSUE: begin
          r_lsu_we <= 1'b0;
          if (r_we) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_tag   <= r_tag;
            r_rsp_we    <= 1'b1;
            r_rsp_fault <= 1'b0;
          end else begin
            r_state <= WAIT;
            r_cnt   <= CNT_W'(READ_LATENCY - 1);
          end
        end

        WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= lsu_data_i;
            r_rsp_tag   <= r_tag;
            r_rsp_we    <= 1'b0;
            r_rsp_fault <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        RESP: begin
          if (bus.rsp_ready_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
